// File: rtl/udp_pack_pkg.sv
// Shared types and constants for the UDP payload packer.
package udp_pack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int unsigned PAYLOAD_BITS    = 960;
    localparam int unsigned MAX_BYTES_LIMIT = 120;
    localparam int unsigned CNT_W           = 7;
    localparam int unsigned IDLE_W          = 16;
    localparam int unsigned LEN_W           = 16;
    localparam int unsigned MSB_W           = 10;

    // Top bit of byte slot k; byte 0 lands in the payload MSB.
    function automatic logic [MSB_W-1:0] byte_msb(input logic [CNT_W-1:0] k);
        return MSB_W'(PAYLOAD_BITS - 1 - 8 * 32'(k));
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Loadable/clearable saturating counter with a terminal-count flag.
module pack_idle_timer
    import udp_pack_pkg::*;
#(
    parameter int unsigned     W        = IDLE_W,
    parameter logic [W-1:0]    TC_VALUE = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic         tc_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Clear wins over load; increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    assign tc_c = (count_q == TC_VALUE);

endmodule

// File: rtl/udp_payload_packer.sv
// Packs a byte stream MSB-first into one wide UDP payload word and holds it
// until the transmitter acknowledges; flushes on last, full, or idle timeout.
module udp_payload_packer
    import udp_pack_pkg::*;
#(
    parameter int unsigned DATA_W         = 961,
    parameter int unsigned MAX_BYTES      = 120,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              udp_send_data_valid,
    input  logic              udp_send_data_ack,
    output logic [DATA_W-1:0] udp_send_data,
    output logic [15:0]       udp_send_data_length,
    output logic              busy,
    output logic              ack_spurious
);

    localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDLE_W-1:0] TC_VALUE   = TIMEOUT_EN ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_BYTES);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    valid_q, valid_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    spur_q, spur_d;

    logic                    accept;
    logic                    idle_inc;
    logic                    idle_tc;
    logic                    timeout;
    logic [CNT_W-1:0]        cnt_inc;
    logic [MSB_W-1:0]        wr_msb;

    assign accept   = in_valid & ready_q;
    assign idle_inc = (state_q == FILL) & ~accept;
    assign timeout  = TIMEOUT_EN & idle_inc & idle_tc;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign wr_msb   = byte_msb(cnt_q);

    pack_idle_timer #(
        .W        (IDLE_W),
        .TC_VALUE (TC_VALUE)
    ) u_idle_timer (
        .clk        (clk),
        .rst_n      (rstn),
        .clear_i    (accept | (state_q != FILL)),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (idle_inc),
        .tc_c       (idle_tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            spur_q  <= spur_d;
        end
    end

    // An ack outside SEND (including the FILL->SEND cycle) never moves the FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        len_d   = len_q;
        spur_d  = spur_q | (udp_send_data_ack & (state_q != SEND));
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d[wr_msb -: 8] = in_data;
                    cnt_d              = CNT_W'(1);
                    if (in_last || (MAX_BYTES == 1)) begin
                        state_d = SEND;
                        len_d   = LEN_W'(1);
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (accept) begin
                    buf_d[wr_msb -: 8] = in_data;
                    cnt_d              = cnt_inc;
                    if (in_last || (cnt_inc == MAX_CNT)) begin
                        state_d = SEND;
                        len_d   = LEN_W'(cnt_inc);
                    end
                end else if (timeout) begin
                    state_d = SEND;
                    len_d   = LEN_W'(cnt_q);
                end
            end
            SEND: begin
                if (udp_send_data_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    buf_d   = '0;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == SEND);
        ready_d = (state_d != SEND);
        busy_d  = (state_d != IDLE);
    end

    assign in_ready             = ready_q;
    assign udp_send_data_valid  = valid_q;
    assign udp_send_data        = DATA_W'({1'b0, buf_q});
    assign udp_send_data_length = len_q;
    assign busy                 = busy_q;
    assign ack_spurious         = spur_q;

endmodule

// File: tb/tb_udp_payload_packer.sv
// Directed self-checking bench for udp_payload_packer (timeout set to 100 cycles).
module tb_udp_payload_packer;

    localparam int unsigned DATA_W = 961;

    logic              clk;
    logic              rstn;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              udp_send_data_valid;
    logic              udp_send_data_ack;
    logic [DATA_W-1:0] udp_send_data;
    logic [15:0]       udp_send_data_length;
    logic              busy;
    logic              ack_spurious;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_d;

    udp_payload_packer #(
        .DATA_W         (DATA_W),
        .MAX_BYTES      (120),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_last              (in_last),
        .in_ready             (in_ready),
        .udp_send_data_valid  (udp_send_data_valid),
        .udp_send_data_ack    (udp_send_data_ack),
        .udp_send_data        (udp_send_data),
        .udp_send_data_length (udp_send_data_length),
        .busy                 (busy),
        .ack_spurious         (ack_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_ack();
        udp_send_data_ack = 1'b1;
        step();
        udp_send_data_ack = 1'b0;
    endtask

    task automatic put_exp(input int k, input logic [7:0] b);
        exp_d[959 - 8 * k -: 8] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        logic stable;
        logic [DATA_W-1:0] snap_d;
        logic [15:0]       snap_l;

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; udp_send_data_ack = 1'b0;

        // Reset state
        #12;
        check_eq("rst_ready", 64'(in_ready), 64'd0);
        check_eq("rst_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("rst_len", 64'(udp_send_data_length), 64'd0);
        check_eq("rst_data_zero", 64'(udp_send_data == '0), 64'd1);
        check_eq("rst_busy_spur", 64'({busy, ack_spurious}), 64'd0);
        rstn = 1'b1;
        step();
        check_eq("rel_ready", 64'(in_ready), 64'd1);

        // Three-byte message with in_last
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        exp_d = '0; put_exp(0, 8'h11); put_exp(1, 8'h22); put_exp(2, 8'h33);
        check_eq("t1_valid", 64'(udp_send_data_valid), 64'd1);
        check_eq("t1_len", 64'(udp_send_data_length), 64'd3);
        check_eq("t1_top", 64'(udp_send_data[959:936]), 64'h112233);
        check_eq("t1_data_all", 64'(udp_send_data == exp_d), 64'd1);
        check_eq("t1_ready", 64'(in_ready), 64'd0);
        do_ack();
        check_eq("t1_ack_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t1_ack_len", 64'(udp_send_data_length), 64'd0);
        check_eq("t1_ack_data", 64'(udp_send_data == '0), 64'd1);

        // Full buffer: 120 bytes 0x00..0x77
        exp_d = '0;
        for (int i = 0; i < 120; i++) begin
            if (i == 119) check_eq("t2_not_early", 64'(udp_send_data_valid), 64'd0);
            send_byte(8'(i), 1'b0);
            put_exp(i, 8'(i));
        end
        check_eq("t2_valid", 64'(udp_send_data_valid), 64'd1);
        check_eq("t2_len", 64'(udp_send_data_length), 64'd120);
        check_eq("t2_low", 64'(udp_send_data[7:0]), 64'h77);
        check_eq("t2_data_all", 64'(udp_send_data == exp_d), 64'd1);
        in_valid = 1'b1; in_data = 8'hAB;
        step(); step(); step();
        check_eq("t2_stall_ready", 64'(in_ready), 64'd0);
        check_eq("t2_stall_len", 64'(udp_send_data_length), 64'd120);
        check_eq("t2_stall_low", 64'(udp_send_data[7:0]), 64'h77);
        do_ack();
        check_eq("t2_ack_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t2_ack_ready", 64'(in_ready), 64'd1);
        check_eq("t2_ack_busy", 64'(busy), 64'd0);
        step();
        in_valid = 1'b0;
        check_eq("t2_next_busy", 64'(busy), 64'd1);
        check_eq("t2_next_byte", 64'(udp_send_data[959:952]), 64'hAB);
        send_byte(8'hCD, 1'b1);
        check_eq("t2_next_len", 64'(udp_send_data_length), 64'd2);
        check_eq("t2_next_data", 64'(udp_send_data[959:944]), 64'hABCD);
        do_ack();

        // Inactivity timeout after five bytes
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        n = 0;
        while (!udp_send_data_valid && n < 200) begin
            step();
            n++;
        end
        check_eq("t3_timeout_cycles", 64'(n), 64'd100);
        check_eq("t3_len", 64'(udp_send_data_length), 64'd5);
        check_eq("t3_data", 64'(udp_send_data[959:920]), 64'hA0A1A2A3A4);
        do_ack();

        // Lone in_last is ignored; then long hold in SEND
        send_byte(8'h3C, 1'b0);
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        check_eq("t4_lone_last", 64'(udp_send_data_valid), 64'd0);
        send_byte(8'h4D, 1'b1);
        snap_d = udp_send_data;
        snap_l = udp_send_data_length;
        check_eq("t4_len", 64'(snap_l), 64'd2);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (udp_send_data !== snap_d || udp_send_data_length !== snap_l || udp_send_data_valid !== 1'b1)
                stable = 1'b0;
        end
        check_eq("t4_stable", 64'(stable), 64'd1);
        do_ack();
        check_eq("t4_ack_valid", 64'(udp_send_data_valid), 64'd0);
        check_eq("t4_ack_len", 64'(udp_send_data_length), 64'd0);
        check_eq("t4_ack_ready", 64'(in_ready), 64'd1);
        send_byte(8'h5A, 1'b1);
        check_eq("t4_new_len", 64'(udp_send_data_length), 64'd1);
        check_eq("t4_new_byte", 64'(udp_send_data[959:952]), 64'h5A);
        do_ack();

        // Spurious ack in IDLE and in FILL
        check_eq("t5_spur_clear", 64'(ack_spurious), 64'd0);
        do_ack();
        check_eq("t5_idle_spur", 64'(ack_spurious), 64'd1);
        check_eq("t5_idle_busy", 64'(busy), 64'd0);
        send_byte(8'h01, 1'b0);
        do_ack();
        check_eq("t5_fill_state", 64'({busy, udp_send_data_valid}), 64'b10);
        send_byte(8'h02, 1'b1);
        check_eq("t5_fill_len", 64'(udp_send_data_length), 64'd2);
        do_ack();

        // Reset mid-FILL with seven bytes held
        for (int i = 0; i < 7; i++) send_byte(8'hE0 + 8'(i), 1'b0);
        check_eq("t6_pre_busy", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        check_eq("t6_rst_flags", 64'({in_ready, udp_send_data_valid, busy, ack_spurious}), 64'd0);
        check_eq("t6_rst_len", 64'(udp_send_data_length), 64'd0);
        check_eq("t6_rst_data", 64'(udp_send_data == '0), 64'd1);
        #2;
        rstn = 1'b1;
        step();
        send_byte(8'h9C, 1'b1);
        exp_d = '0; put_exp(0, 8'h9C);
        check_eq("t6_len", 64'(udp_send_data_length), 64'd1);
        check_eq("t6_data", 64'(udp_send_data == exp_d), 64'd1);
        do_ack();

        // Ack coincident with FILL->SEND is ignored
        send_byte(8'h10, 1'b0);
        in_valid = 1'b1; in_data = 8'h20; in_last = 1'b1; udp_send_data_ack = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0; udp_send_data_ack = 1'b0;
        check_eq("t7_valid", 64'(udp_send_data_valid), 64'd1);
        check_eq("t7_spur", 64'(ack_spurious), 64'd1);
        check_eq("t7_len", 64'(udp_send_data_length), 64'd2);
        step(); step(); step();
        check_eq("t7_pending", 64'(udp_send_data_valid), 64'd1);
        do_ack();
        check_eq("t7_done", 64'({udp_send_data_valid, in_ready}), 64'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udp_payload_packer.md
Name: udp_payload_packer

Overview:
- Upstream feeder for the Ethernet/UDP top-level, in the clk (50 MHz) domain.
- Collects a byte stream from user logic into one wide payload word (udp_send_data) with a byte count (udp_send_data_length).
- Raises udp_send_data_valid and holds it until the top-level's synchronised ready-posedge pulse acknowledges the frame.
- Flushes on in_last, on a full buffer, or on an inactivity timeout.

Parameters:
- DATA_W, 961, width of udp_send_data; payload occupies bits [959:0], bit 960 is always 0.
- MAX_BYTES, 120, buffer capacity in bytes (DATA_W-1)/8; must be ≤ 120.
- TIMEOUT_CYCLES, 50000, idle clk cycles in FILL before a partial buffer is flushed; 0 disables the timeout.

Ports:
- clk  input  1  system clock (clk_50m domain)
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_data  input  8  input byte
- in_last  input  1  marks last byte of a message; forces a flush
- in_ready  output  1  packer can accept a byte this cycle
- udp_send_data_valid  output  1  frame ready for the UDP transmitter; level signal
- udp_send_data_ack  input  1  one-cycle pulse, top-level's synchronised ready posedge; completes the handshake
- udp_send_data  output  DATA_W  packed payload
- udp_send_data_length  output  16  payload byte count, 1..MAX_BYTES
- busy  output  1  state != IDLE
- ack_spurious  output  1  sticky; set by an ack pulse outside SEND, cleared only by reset

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, byte count cnt=0, idle counter=0.
  - All outputs 0, including in_ready; in_ready goes to 1 on the first clk after release.
- States:
  - IDLE: no bytes held.
  - FILL: 1..MAX_BYTES-1 bytes held.
  - SEND: udp_send_data_valid=1.
- in_ready = (state != SEND). A byte is accepted when in_valid & in_ready.
- Packing:
  - Byte k (0-based) is written to bits [959-8k -: 8], so the first byte is in the MSB.
  - Bytes not written are 0; the buffer is cleared to 0 when leaving SEND.
- IDLE, accept:
  - Store the byte and set cnt=1.
  - If in_last, or MAX_BYTES==1, go to SEND with length=1.
  - Otherwise go to FILL.
- FILL, accept:
  - Store the byte and set cnt=cnt+1.
  - If in_last or cnt+1==MAX_BYTES, go to SEND with length=cnt+1.
  - Otherwise stay in FILL and reset the idle counter.
- FILL, no accept:
  - The idle counter increments.
  - When it reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES≠0), go to SEND with length=cnt.
- Latency: the last byte accepted in cycle N gives udp_send_data_valid=1 in cycle N+1.
- Data and length are registered and stable for the whole of SEND.
- SEND:
  - Hold until udp_send_data_ack=1, then go to IDLE next cycle: valid=0, cnt=0, buffer cleared, length=0.
  - in_ready returns to 1 in the cycle after ack.
- Ack pulse in IDLE or FILL: ignored for state purposes; sets ack_spurious.
- Ack in the same cycle as the FILL→SEND transition: ignored. The frame stays pending and ack_spurious is set.
- in_last with in_valid=0 has no effect.
- in_valid while in SEND is not accepted; the byte is held upstream by in_ready=0.
- Reset mid-SEND or mid-FILL: the frame is discarded with no partial output.
- Width rules:
  - cnt is 7 bits and never exceeds MAX_BYTES.
  - The idle counter is 16 bits and saturates.
  - Length is zero-extended to 16 bits.

Decomposition:
- Package udp_pack_pkg:
  - state enum {IDLE, FILL, SEND}.
  - Constants PAYLOAD_BITS=960 and MAX_BYTES_LIMIT=120.
  - Function byte_msb(k) = 959-8k.
- Sub-module pack_idle_timer: loadable/clearable saturating counter with a terminal-count output. Used for the timeout, reusable by the receive side.

Test Plan:
- Reset, then send bytes 0x11,0x22,0x33 with in_last on 0x33 -> valid=1 one cycle after 0x33; length=3; data[959:936]=0x112233; all other bits 0; in_ready=0.
- Send 120 bytes 0x00..0x77, no in_last -> SEND after byte 0x77; length=120; data[7:0]=0x77; 121st byte stalls (in_ready=0) until ack.
- Send 5 bytes, then idle with TIMEOUT_CYCLES=100 -> valid rises exactly 100 cycles after the last accept; length=5.
- In SEND, hold 40 cycles without ack, then pulse ack -> data/length stable throughout; next cycle valid=0, length=0, in_ready=1; a new byte is accepted the cycle after.
- Ack pulse in IDLE, and ack coincident with the FILL→SEND cycle -> no state change; ack_spurious=1; frame still pending; a later ack completes it.
- Assert rstn=0 mid-FILL (cnt=7) -> all outputs 0 immediately; after release a 1-byte message gives length=1, not 8.
